// File: rtl/shared_pkg.sv
// Shared types and constants for the FIFO drain packer: data width, FSM states,
// default header marker and the word record carried through the output buffer.
package shared_pkg;

  localparam int unsigned FIFO_WIDTH = 16;
  localparam logic [7:0]  SYNC_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    CSUM    = 2'd3
  } state_e;

  typedef struct packed {
    logic                  sof;
    logic                  last;
    logic [FIFO_WIDTH-1:0] data;
  } word_t;

endpackage

// File: rtl/fifo_drain_packer_if.sv
// Upstream FIFO read port plus the framed output stream of the drain packer.
interface fifo_drain_packer_if;

  logic [shared_pkg::FIFO_WIDTH-1:0] fifo_data_out;
  logic                              fifo_empty;
  logic                              fifo_underflow;
  logic                              fifo_rd_en;
  logic [shared_pkg::FIFO_WIDTH-1:0] m_data;
  logic                              m_valid;
  logic                              m_ready;
  logic                              m_sof;
  logic                              m_last;
  logic [7:0]                        frame_seq;
  logic                              err_underflow;

  modport master (
    input  fifo_data_out, fifo_empty, fifo_underflow, m_ready,
    output fifo_rd_en, m_data, m_valid, m_sof, m_last, frame_seq, err_underflow
  );

  modport slave (
    output fifo_data_out, fifo_empty, fifo_underflow, m_ready,
    input  fifo_rd_en, m_data, m_valid, m_sof, m_last, frame_seq, err_underflow
  );

endinterface

// File: rtl/fifo_drain_skid.sv
// Two-entry output buffer; the head entry drives the outgoing stream directly
// from flops. flush is a synchronous clear that also serves as reset.
module fifo_drain_skid
  import shared_pkg::*;
(
  input  logic       clk,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready_c,
  input  word_t      in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output word_t      out_data,
  output logic [1:0] count
);

  word_t      head_q, head_d;
  word_t      tail_q, tail_d;
  logic [1:0] count_q, count_d;
  logic       valid_q, valid_d;
  logic       push_c;
  logic       pop_c;

  assign in_ready_c = (count_q != 2'd2) || out_ready;
  assign out_valid  = valid_q;
  assign out_data   = head_q;
  assign count      = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    pop_c   = valid_q && out_ready;
    push_c  = in_valid && in_ready_c;
    case ({push_c, pop_c})
      2'b10: begin
        if (count_q == 2'd0) head_d = in_data;
        else                 tail_d = in_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        // Keep the last word on the bus when draining to empty.
        if (count_q == 2'd2) head_d = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = in_data;
        end else begin
          head_d = tail_q;
          tail_d = in_data;
        end
      end
      default: ;
    endcase
    valid_d = (count_d != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/fifo_drain_packer.sv
// Drains an upstream FIFO into frames: header (SYNC + sequence), FRAME_LEN
// payload words, then a modular-sum checksum word.
module fifo_drain_packer
  import shared_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 4,
  parameter logic [7:0]  SYNC      = SYNC_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  fifo_drain_packer_if.master bus
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned SEQ_PAD = FIFO_WIDTH - 8;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]      tx_cnt_q, tx_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [FIFO_WIDTH-1:0] csum_q, csum_d;
  logic [7:0]            seq_q, seq_d;
  logic                  err_q, err_d;

  logic       skid_in_valid;
  logic       skid_in_ready_c;
  word_t      skid_in;
  logic       skid_out_valid;
  word_t      skid_out;
  logic [1:0] skid_count;
  logic       pop_c;
  logic       rd_en_c;
  logic [2:0] pending_c;

  fifo_drain_skid u_skid (
    .clk        (clk),
    .flush      (rst),
    .in_valid   (skid_in_valid),
    .in_ready_c (skid_in_ready_c),
    .in_data    (skid_in),
    .out_valid  (skid_out_valid),
    .out_ready  (bus.m_ready),
    .out_data   (skid_out),
    .count      (skid_count)
  );

  assign pop_c = skid_out_valid && bus.m_ready;

  assign bus.fifo_rd_en    = rd_en_c;
  assign bus.m_data        = skid_out.data;
  assign bus.m_valid       = skid_out_valid;
  assign bus.m_sof         = skid_out.sof;
  assign bus.m_last        = skid_out.last;
  assign bus.frame_seq     = seq_q;
  assign bus.err_underflow = err_q;

  // Next-state, read issue and buffer feed.
  always_comb begin
    state_d       = state_q;
    rd_cnt_d      = rd_cnt_q;
    tx_cnt_d      = tx_cnt_q;
    csum_d        = csum_q;
    seq_d         = seq_q;
    skid_in_valid = 1'b0;
    skid_in       = '0;
    err_d         = err_q | bus.fifo_underflow;

    // Words left in the buffer after this cycle's pop, plus the read awaiting data.
    pending_c = 3'(skid_count) - 3'(pop_c) + 3'(inflight_q);
    rd_en_c   = !rst && (state_q == PAYLOAD) && !bus.fifo_empty &&
                (rd_cnt_q < CNT_W'(FRAME_LEN)) && (pending_c < 3'd2);
    inflight_d = rd_en_c;
    if (rd_en_c) rd_cnt_d = rd_cnt_q + CNT_W'(1);

    if (inflight_q) begin
      skid_in_valid = 1'b1;
      skid_in       = '{sof: 1'b0, last: 1'b0, data: bus.fifo_data_out};
      csum_d        = csum_q + bus.fifo_data_out;
    end

    case (state_q)
      IDLE: begin
        if (!bus.fifo_empty && skid_in_ready_c) begin
          skid_in_valid = 1'b1;
          skid_in       = '{sof: 1'b1, last: 1'b0, data: {SYNC, SEQ_PAD'(seq_q)}};
          state_d       = HDR;
        end
      end
      HDR: begin
        if (pop_c) state_d = PAYLOAD;
      end
      PAYLOAD: begin
        if (pop_c) begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
          // All captures precede the final payload transfer, so csum_q is complete here.
          if (tx_cnt_q == CNT_W'(FRAME_LEN - 1)) begin
            skid_in_valid = 1'b1;
            skid_in       = '{sof: 1'b0, last: 1'b1, data: csum_q};
            state_d       = CSUM;
          end
        end
      end
      CSUM: begin
        if (pop_c) begin
          seq_d    = seq_q + 8'd1;
          rd_cnt_d = '0;
          tx_cnt_d = '0;
          csum_d   = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      inflight_q <= 1'b0;
      csum_q     <= '0;
      seq_q      <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      inflight_q <= inflight_d;
      csum_q     <= csum_d;
      seq_q      <= seq_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_fifo_drain_packer.sv
// Bench for fifo_drain_packer: queue-based FIFO model, frame-level reference
// model feeding a scoreboard, and a monitor checking every output transfer.
module tb_fifo_drain_packer;
  import shared_pkg::*;

  localparam int unsigned FL     = 4;
  localparam logic [7:0]  SYNC_V = 8'hA5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_drain_packer_if bus();

  fifo_drain_packer #(.FRAME_LEN(FL), .SYNC(SYNC_V)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_xfer = 0;
  int rmode  = 0;
  int rphase = 0;
  bit tput_chk = 1'b0;

  logic [FIFO_WIDTH-1:0] fifo_q[$];
  word_t                 exp_q[$];

  logic [7:0]            mdl_seq;
  int                    mdl_idx;
  logic [FIFO_WIDTH-1:0] mdl_sum;

  // Upstream FIFO: read data appears the cycle after an accepted read.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.fifo_rd_en) begin
      total++;
      if (fifo_q.size() == 0) begin
        bad++;
        $display("FAIL rd_on_empty: fifo_rd_en=1 with empty FIFO, required 0 (cycle %0d)", cyc);
      end else begin
        bus.fifo_data_out <= fifo_q.pop_front();
      end
    end
  end

  // Monitor: every transfer is popped from the scoreboard and compared.
  word_t                 mon_e;
  bit                    prv_stall = 1'b0;
  logic [FIFO_WIDTH-1:0] prv_data;
  logic                  prv_sof, prv_last;
  int                    hdr_cyc, first_cyc, pay_n;

  always @(negedge clk) begin
    if (rst) begin
      prv_stall = 1'b0;
    end else begin
      if (prv_stall) begin
        total++;
        if (!(bus.m_valid && bus.m_data == prv_data && bus.m_sof == prv_sof && bus.m_last == prv_last)) begin
          bad++;
          $display("FAIL stall_hold: got v=%0b d=%h sof=%0b last=%0b, required v=1 d=%h sof=%0b last=%0b",
                   bus.m_valid, bus.m_data, bus.m_sof, bus.m_last, prv_data, prv_sof, prv_last);
        end
      end
      if (bus.m_valid && bus.m_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_word: got d=%h sof=%0b last=%0b, required no transfer",
                   bus.m_data, bus.m_sof, bus.m_last);
        end else begin
          mon_e = exp_q.pop_front();
          if (bus.m_data !== mon_e.data || bus.m_sof !== mon_e.sof || bus.m_last !== mon_e.last) begin
            bad++;
            $display("FAIL out_word: got d=%h sof=%0b last=%0b, required d=%h sof=%0b last=%0b",
                     bus.m_data, bus.m_sof, bus.m_last, mon_e.data, mon_e.sof, mon_e.last);
          end
        end
        n_xfer++;
        if (bus.m_sof) begin
          hdr_cyc = cyc;
          pay_n   = 0;
        end else if (!bus.m_last) begin
          if (pay_n == 0) first_cyc = cyc;
          pay_n++;
        end else if (tput_chk) begin
          total++;
          if ((cyc - first_cyc) != int'(FL) || (first_cyc - hdr_cyc) > 3) begin
            bad++;
            $display("FAIL throughput: got hdr->pay=%0d pay->csum=%0d, required <=3 and %0d",
                     first_cyc - hdr_cyc, cyc - first_cyc, FL);
          end
        end
      end
      prv_stall = bus.m_valid && !bus.m_ready;
      prv_data  = bus.m_data;
      prv_sof   = bus.m_sof;
      prv_last  = bus.m_last;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic model_clear();
    mdl_seq = 8'd0;
    mdl_idx = 0;
    mdl_sum = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    case (rmode)
      0:       bus.m_ready = 1'b1;
      1:       bus.m_ready = (rphase % 3 == 0);
      default: bus.m_ready = ($urandom_range(9) < 7);
    endcase
    rphase++;
    bus.fifo_empty = (fifo_q.size() == 0);
  endtask

  // Reference model: frame boundaries follow from the count of pushed words.
  task automatic push_word(input logic [FIFO_WIDTH-1:0] w);
    fifo_q.push_back(w);
    bus.fifo_empty = 1'b0;
    if (mdl_idx == 0)
      exp_q.push_back('{sof: 1'b1, last: 1'b0, data: {SYNC_V, (FIFO_WIDTH-8)'(mdl_seq)}});
    exp_q.push_back('{sof: 1'b0, last: 1'b0, data: w});
    mdl_sum = mdl_sum + w;
    mdl_idx++;
    if (mdl_idx == int'(FL)) begin
      exp_q.push_back('{sof: 1'b0, last: 1'b1, data: mdl_sum});
      mdl_seq = mdl_seq + 8'd1;
      mdl_idx = 0;
      mdl_sum = '0;
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d words pending, required 0", exp_q.size());
    end
    repeat (3) tick();
  endtask

  task automatic do_reset(input int n, input string tag);
    rst = 1'b1;
    bus.m_ready = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    model_clear();
    repeat (n) tick();
    rst = 1'b0;
    chk({tag, "_m_valid"},   32'(bus.m_valid), 32'd0);
    chk({tag, "_m_data"},    32'(bus.m_data), 32'd0);
    chk({tag, "_m_sof"},     32'(bus.m_sof), 32'd0);
    chk({tag, "_m_last"},    32'(bus.m_last), 32'd0);
    chk({tag, "_frame_seq"}, 32'(bus.frame_seq), 32'd0);
    chk({tag, "_err"},       32'(bus.err_underflow), 32'd0);
    chk({tag, "_rd_en"},     32'(bus.fifo_rd_en), 32'd0);
  endtask

  task automatic push_1234();
    for (int i = 1; i <= 4; i++) push_word(FIFO_WIDTH'(i));
  endtask

  initial begin
    int base;
    int n;
    rst = 1'b1;
    bus.m_ready = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_underflow = 1'b0;
    model_clear();

    do_reset(2, "reset");

    // Basic frame with sustained sink and a preloaded FIFO.
    rmode = 0;
    tput_chk = 1'b1;
    push_1234();
    wait_drain(100);
    tput_chk = 1'b0;
    chk("seq_basic", 32'(bus.frame_seq), 32'(mdl_seq));

    // Checksum wraps modulo 2^16.
    push_word(16'hFFFF);
    push_word(16'h0002);
    push_word(16'h0000);
    push_word(16'h0000);
    wait_drain(100);

    // Backpressure pattern 1,0,0,...
    rmode = 1;
    rphase = 0;
    push_1234();
    wait_drain(200);
    rmode = 0;

    // FIFO runs dry mid-frame.
    push_word(16'h0001);
    push_word(16'h0002);
    repeat (20) tick();
    chk("valid_drops_in_gap", 32'(bus.m_valid), 32'd0);
    push_word(16'h0003);
    push_word(16'h0004);
    wait_drain(100);
    chk("seq_gap", 32'(bus.frame_seq), 32'(mdl_seq));

    // Random data, random push spacing, random sink readiness.
    rmode = 2;
    for (int i = 0; i < 24 * int'(FL); i++) begin
      push_word(FIFO_WIDTH'($urandom));
      repeat ($urandom_range(2)) tick();
    end
    wait_drain(3000);
    rmode = 0;
    chk("seq_random", 32'(bus.frame_seq), 32'(mdl_seq));

    // Reset after the second payload word leaves.
    base = n_xfer;
    push_1234();
    n = 0;
    while (n_xfer < base + 3 && n < 50) begin
      tick();
      n++;
    end
    if (n_xfer < base + 3) begin
      total++;
      bad++;
      $display("FAIL midframe_wait: got %0d transfers, required 3", n_xfer - base);
    end
    do_reset(1, "midreset");
    push_1234();
    wait_drain(100);
    chk("seq_after_reset", 32'(bus.frame_seq), 32'd1);

    // Sticky underflow.
    bus.fifo_underflow = 1'b1;
    tick();
    bus.fifo_underflow = 1'b0;
    tick();
    chk("err_set", 32'(bus.err_underflow), 32'd1);

    // 257 back-to-back frames: header sequence byte wraps through 00.
    do_reset(1, "prewrap");
    bus.fifo_underflow = 1'b1;
    tick();
    bus.fifo_underflow = 1'b0;
    tput_chk = 1'b1;
    for (int i = 0; i < 257 * int'(FL); i++) push_word(FIFO_WIDTH'($urandom));
    wait_drain(5000);
    tput_chk = 1'b0;
    chk("seq_wrap", 32'(bus.frame_seq), 32'd1);
    chk("err_sticky", 32'(bus.err_underflow), 32'd1);

    do_reset(2, "final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
